// File: rtl/posit_dec_arbiter.sv
// posit_dec_arbiter: two requesters share one combinational posit decoder.
// A round-robin arbiter picks one valid request per cycle, decodes it and
// registers the fields, plus a requester tag, into a single output stage.
//
// Optional feature (macro POSIT_DEC_CNT_EN): per-requester saturating grant
// counters cnt0/cnt1 with a synchronous clear input cnt_clr.
//
// Ports:
//   clk, rst_n                      clock (rising edge), async active-low reset
//   req{0,1}_valid/_data/_ready     requester handshakes (ready is combinational)
//   out_valid/out_ready             output stage handshake
//   out_tag                         requester index of the held result
//   out_sign/regi/expo/frac         decoded posit fields
//   out_allone/out_allzero          all non-sign bits one / zero
//   cnt_clr, cnt0, cnt1             grant counters (POSIT_DEC_CNT_EN only)

// decoder: combinational posit field extraction.
//   o_sign    : sign bit of the raw word
//   o_regi    : regime value k (two's complement, rs bits); a run of m
//               identical bits after the sign gives k=m-1 (ones) or k=-m (zeros)
//   o_expo    : es exponent bits following the regime terminator (0 if absent)
//   o_frac    : remaining bits, left-aligned in fs bits, zero padded
//   o_allone  : all non-sign raw bits are 1
//   o_allzero : all non-sign raw bits are 0
// Negative words are two's-complemented before field extraction.
module decoder #(
  parameter int n  = 16,
  parameter int es = 1,
  parameter int rs = 5,
  parameter int fs = n - es - 3
) (
  input  logic [n-1:0]  i_word,
  output logic          o_sign,
  output logic [rs-1:0] o_regi,
  output logic [es-1:0] o_expo,
  output logic [fs-1:0] o_frac,
  output logic          o_allone,
  output logic          o_allzero
);
  localparam int BW = n - 1;
  localparam int CW = $clog2(n);

  logic [BW-1:0] w_body;
  logic [CW-1:0] w_run;
  logic          w_stop;

  always_comb begin
    w_body = i_word[n-1] ? BW'(-i_word) : i_word[BW-1:0];
    w_run  = '0;
    w_stop = 1'b0;
    for (int unsigned i = 0; i < BW; i++) begin
      if (!w_stop && (w_body[BW-1-i] == w_body[BW-1])) w_run = w_run + CW'(1);
      else                                            w_stop = 1'b1;
    end
    o_regi = w_body[BW-1] ? (rs'(w_run) - rs'(1)) : (rs'(0) - rs'(w_run));
    // Shift out regime run plus terminator, then keep the top es+fs bits.
    {o_expo, o_frac} = (es + fs)'((w_body << (int'(w_run) + 1)) >> (BW - es - fs));
  end

  assign o_sign    = i_word[n-1];
  assign o_allone  = &i_word[n-2:0];
  assign o_allzero = ~|i_word[n-2:0];
endmodule

module posit_dec_arbiter #(
  parameter int N  = 16,
  parameter int ES = 1,
  parameter int RS = 5,
  parameter int FS = N - ES - 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  input  logic [N-1:0]  req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [N-1:0]  req1_data,
  output logic          req1_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_tag,
  output logic          out_sign,
  output logic [RS-1:0] out_regi,
  output logic [ES-1:0] out_expo,
  output logic [FS-1:0] out_frac,
  output logic          out_allone,
  output logic          out_allzero
`ifdef POSIT_DEC_CNT_EN
  ,
  input  logic          cnt_clr,
  output logic [15:0]   cnt0,
  output logic [15:0]   cnt1
`endif
);
  logic          r_valid, r_tag, r_sign, r_allone, r_allzero, r_rr_ptr;
  logic [RS-1:0] r_regi;
  logic [ES-1:0] r_expo;
  logic [FS-1:0] r_frac;

  logic          w_free, w_gnt0, w_gnt1, w_gnt;
  logic [N-1:0]  w_dec_in;
  logic          w_sign, w_allone, w_allzero;
  logic [RS-1:0] w_regi;
  logic [ES-1:0] w_expo;
  logic [FS-1:0] w_frac;

  assign w_free = !r_valid || out_ready;
  // Grants are masked while reset is held so no request is acknowledged
  // during reset even though the empty stage would otherwise accept.
  assign w_gnt0 = rst_n && w_free && req0_valid && (!req1_valid || !r_rr_ptr);
  assign w_gnt1 = rst_n && w_free && req1_valid && (!req0_valid ||  r_rr_ptr);
  assign w_gnt  = w_gnt0 || w_gnt1;

  assign w_dec_in = w_gnt1 ? req1_data : req0_data;

  decoder #(.n(N), .es(ES), .rs(RS), .fs(FS)) u_dec (
    .i_word    (w_dec_in),
    .o_sign    (w_sign),
    .o_regi    (w_regi),
    .o_expo    (w_expo),
    .o_frac    (w_frac),
    .o_allone  (w_allone),
    .o_allzero (w_allzero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_tag     <= 1'b0;
      r_sign    <= 1'b0;
      r_regi    <= '0;
      r_expo    <= '0;
      r_frac    <= '0;
      r_allone  <= 1'b0;
      r_allzero <= 1'b0;
      r_rr_ptr  <= 1'b0;
    end else if (w_gnt) begin
      r_valid   <= 1'b1;
      r_tag     <= w_gnt1;
      r_sign    <= w_sign;
      r_regi    <= w_regi;
      r_expo    <= w_expo;
      r_frac    <= w_frac;
      r_allone  <= w_allone;
      r_allzero <= w_allzero;
      r_rr_ptr  <= w_gnt0;
    end else if (out_ready) begin
      r_valid   <= 1'b0;
    end
  end

  assign req0_ready  = w_gnt0;
  assign req1_ready  = w_gnt1;
  assign out_valid   = r_valid;
  assign out_tag     = r_tag;
  assign out_sign    = r_sign;
  assign out_regi    = r_regi;
  assign out_expo    = r_expo;
  assign out_frac    = r_frac;
  assign out_allone  = r_allone;
  assign out_allzero = r_allzero;

`ifdef POSIT_DEC_CNT_EN
  logic [15:0] r_cnt0, r_cnt1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else if (cnt_clr) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_gnt0 && (r_cnt0 != '1)) r_cnt0 <= r_cnt0 + 16'd1;
      if (w_gnt1 && (r_cnt1 != '1)) r_cnt1 <= r_cnt1 + 16'd1;
    end
  end

  assign cnt0 = r_cnt0;
  assign cnt1 = r_cnt1;
`endif
endmodule

// File: tb/tb_posit_dec_arbiter.sv
module tb_posit_dec_arbiter;
  localparam int N = 16, ES = 1, RS = 5, FS = 12;

  typedef struct packed {
    logic        s;
    logic [4:0]  r;
    logic        e;
    logic [11:0] f;
    logic        a1;
    logic        a0;
  } dec_t;

  typedef struct {
    logic [15:0] data;
    dec_t        exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req1_valid, req0_ready, req1_ready;
  logic [N-1:0]  req0_data, req1_data;
  logic          out_valid, out_ready, out_tag, out_sign, out_allone, out_allzero;
  logic [RS-1:0] out_regi;
  logic [ES-1:0] out_expo;
  logic [FS-1:0] out_frac;
`ifdef POSIT_DEC_CNT_EN
  logic          cnt_clr;
  logic [15:0]   cnt0, cnt1;
`endif

  always #5 clk = ~clk;

  posit_dec_arbiter #(.N(N), .ES(ES), .RS(RS), .FS(FS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_tag    (out_tag),
    .out_sign   (out_sign),
    .out_regi   (out_regi),
    .out_expo   (out_expo),
    .out_frac   (out_frac),
    .out_allone (out_allone),
    .out_allzero(out_allzero)
`ifdef POSIT_DEC_CNT_EN
    ,
    .cnt_clr    (cnt_clr),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
`endif
  );

  int n_pass = 0, n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference posit decode from the number format rules, using integers.
  function automatic dec_t ref_decode(input logic [15:0] w);
    int a, body, lead, m, k, rem, rbits, e, f, flen;
    dec_t d;
    a = w[15] ? (65536 - int'(w)) % 65536 : int'(w);
    body = a % 32768;
    lead = body / 16384;
    m = 0;
    while (m < 15 && ((body >> (14 - m)) & 1) == lead) m++;
    k = (lead == 1) ? m - 1 : -m;
    rem = 14 - m;
    if (rem < 0) rem = 0;
    rbits = body % (1 << rem);
    e = 0;
    f = 0;
    if (rem >= 1) begin
      flen = rem - 1;
      e = rbits >> flen;
      f = (rbits % (1 << flen)) << (12 - flen);
    end
    d.s  = w[15];
    d.r  = 5'(k);
    d.e  = 1'(e);
    d.f  = 12'(f);
    d.a1 = (w[14:0] == 15'h7FFF);
    d.a0 = (w[14:0] == 15'h0000);
    return d;
  endfunction

  function automatic dec_t mk(input logic s, input logic [4:0] r, input logic e,
                              input logic [11:0] f, input logic a1, input logic a0);
    dec_t d;
    d.s = s; d.r = r; d.e = e; d.f = f; d.a1 = a1; d.a0 = a0;
    return d;
  endfunction

  function automatic dec_t out_fields();
    return mk(out_sign, out_regi, out_expo, out_frac, out_allone, out_allzero);
  endfunction

  // Behavioural model of the output stage: a one-entry holding slot and the
  // requester that wins the next tie.
  logic m_valid;
  int   m_tag, m_pref;
  dec_t m_dec;

  task automatic model_reset();
    m_valid = 1'b0;
    m_tag   = 0;
    m_pref  = 0;
    m_dec   = '0;
  endtask

  // Checks readies and held outputs mid-cycle, then advances across one edge.
  task automatic cycle_check(input string pfx);
    int win;
    @(negedge clk);
    win = -1;
    if (rst_n && (!m_valid || out_ready)) begin
      if (req0_valid && req1_valid) win = m_pref;
      else if (req0_valid)          win = 0;
      else if (req1_valid)          win = 1;
    end
    chk({pfx, ".req0_ready"}, 32'(req0_ready), 32'(win == 0));
    chk({pfx, ".req1_ready"}, 32'(req1_ready), 32'(win == 1));
    chk({pfx, ".out_valid"},  32'(out_valid),  32'(m_valid));
    if (m_valid) chk({pfx, ".out_tag"}, 32'(out_tag), 32'(m_tag));
    chk({pfx, ".fields"}, 32'(out_fields()), 32'(m_dec));
    @(posedge clk);
    if (win >= 0) begin
      m_valid = 1'b1;
      m_tag   = win;
      m_dec   = ref_decode(win == 1 ? req1_data : req0_data);
      m_pref  = 1 - win;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    cycle_check("rst");
    rst_n = 1'b1;
  endtask

  vec_t tbl[13];
  dec_t held;

  initial begin
    rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = '0; req1_data = '0; out_ready = 1'b1;
`ifdef POSIT_DEC_CNT_EN
    cnt_clr = 1'b0;
`endif
    model_reset();

    tbl[0]  = '{16'h4000, mk(1'b0, 5'h00, 1'b0, 12'h000, 1'b0, 1'b0)};
    tbl[1]  = '{16'h0000, mk(1'b0, 5'h11, 1'b0, 12'h000, 1'b0, 1'b1)};
    tbl[2]  = '{16'h8000, mk(1'b1, 5'h11, 1'b0, 12'h000, 1'b0, 1'b1)};
    tbl[3]  = '{16'h7FFF, mk(1'b0, 5'h0E, 1'b0, 12'h000, 1'b1, 1'b0)};
    tbl[4]  = '{16'h5000, mk(1'b0, 5'h00, 1'b1, 12'h000, 1'b0, 1'b0)};
    tbl[5]  = '{16'h6000, mk(1'b0, 5'h01, 1'b0, 12'h000, 1'b0, 1'b0)};
    tbl[6]  = '{16'h2000, mk(1'b0, 5'h1F, 1'b0, 12'h000, 1'b0, 1'b0)};
    tbl[7]  = '{16'h4801, mk(1'b0, 5'h00, 1'b0, 12'h801, 1'b0, 1'b0)};
    tbl[8]  = '{16'hC000, mk(1'b1, 5'h00, 1'b0, 12'h000, 1'b0, 1'b0)};
    tbl[9]  = '{16'hFFFF, mk(1'b1, 5'h12, 1'b0, 12'h000, 1'b1, 1'b0)};
    tbl[10] = '{16'h7000, mk(1'b0, 5'h02, 1'b0, 12'h000, 1'b0, 1'b0)};
    tbl[11] = '{16'h3400, mk(1'b0, 5'h1F, 1'b1, 12'h400, 1'b0, 1'b0)};
    tbl[12] = '{16'hB7FF, mk(1'b1, 5'h00, 1'b0, 12'h801, 1'b0, 1'b0)};

    // Reset with both requesters asserting: nothing accepted, stage empty.
    @(posedge clk); #1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    rst_n = 1'b0;
    cycle_check("rst_hold");
    cycle_check("rst_hold");
    rst_n = 1'b1;

    // First contended grant after reset goes to req0, then alternates.
    for (int i = 0; i < 6; i++) begin
      req0_data = 16'(($urandom));
      req1_data = 16'(($urandom));
      cycle_check("cont");
      chk("cont.tag_seq", 32'(out_tag), 32'(i % 2));
      chk("cont.valid", 32'(out_valid), 32'd1);
    end

    // Backpressure: stage holds for three cycles, then the pending winner is
    // granted in the release cycle with no bubble.
    out_ready = 1'b0;
    held = out_fields();
    for (int i = 0; i < 3; i++) cycle_check("bp");
    chk("bp.hold_fields", 32'(out_fields()), 32'(held));
    chk("bp.hold_tag", 32'(out_tag), 32'd1);
    out_ready = 1'b1;
    cycle_check("bp_rel");
    chk("bp_rel.valid", 32'(out_valid), 32'd1);
    chk("bp_rel.tag", 32'(out_tag), 32'd0);

    // Table of decode vectors through requester 0.
    apply_reset();
    req1_valid = 1'b0;
    req0_valid = 1'b1;
    foreach (tbl[i]) begin
      req0_data = tbl[i].data;
      cycle_check("tbl");
      chk("tbl.valid", 32'(out_valid), 32'd1);
      chk("tbl.tag", 32'(out_tag), 32'd0);
      chk($sformatf("tbl[%0d].fields", i), 32'(out_fields()), 32'(tbl[i].exp));
    end
    req0_valid = 1'b0;
    cycle_check("tbl_drain");
    chk("tbl_drain.valid", 32'(out_valid), 32'd0);

    // Back-to-back stream from requester 1 with pop+push every cycle.
    req1_valid = 1'b1;
    foreach (tbl[i]) begin
      if (i >= 1 && i <= 3) begin
        req1_data = tbl[i].data;
        cycle_check("stream");
        chk("stream.valid", 32'(out_valid), 32'd1);
        chk("stream.tag", 32'(out_tag), 32'd1);
        chk($sformatf("stream[%0h].fields", tbl[i].data), 32'(out_fields()), 32'(tbl[i].exp));
      end
    end
    req1_valid = 1'b0;
    cycle_check("stream_end");

    // Asynchronous reset while a result is held.
    req0_valid = 1'b1; req1_valid = 1'b1;
    cycle_check("pre_arst");
    chk("pre_arst.valid", 32'(out_valid), 32'd1);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst.valid", 32'(out_valid), 32'd0);
    chk("arst.req0_ready", 32'(req0_ready), 32'd0);
    chk("arst.req1_ready", 32'(req1_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle_check("post_arst");
    chk("post_arst.tag", 32'(out_tag), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      req0_valid = ($urandom_range(0, 3) != 0);
      req1_valid = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      req0_data  = 16'($urandom);
      req1_data  = 16'($urandom);
      cycle_check("rand");
    end
    out_ready = 1'b1;

`ifdef POSIT_DEC_CNT_EN
    apply_reset();
    req1_valid = 1'b0;
    req0_valid = 1'b1;
    for (int i = 0; i < 5; i++) cycle_check("cnt");
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    for (int i = 0; i < 2; i++) cycle_check("cnt");
    req1_valid = 1'b0;
    chk("cnt.cnt0", 32'(cnt0), 32'd5);
    chk("cnt.cnt1", 32'(cnt1), 32'd2);
    cnt_clr = 1'b1;
    cycle_check("cnt_clr");
    cnt_clr = 1'b0;
    chk("cnt_clr.cnt0", 32'(cnt0), 32'd0);
    chk("cnt_clr.cnt1", 32'(cnt1), 32'd0);
    req0_valid = 1'b1;
    cnt_clr = 1'b1;
    cycle_check("cnt_clr_gnt");
    cnt_clr = 1'b0;
    chk("cnt_clr_gnt.cnt0", 32'(cnt0), 32'd0);
    req0_valid = 1'b0;
    force dut.r_cnt0 = 16'hFFFF;
    cycle_check("cnt_sat");
    release dut.r_cnt0;
    req0_valid = 1'b1;
    cycle_check("cnt_sat");
    cycle_check("cnt_sat");
    req0_valid = 1'b0;
    chk("cnt_sat.cnt0", 32'(cnt0), 32'hFFFF);
    chk("cnt_sat.cnt1", 32'(cnt1), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
